// File: rtl/dcache_pkg.sv
// Shared widths, FSM states and line layout for the direct-mapped data cache.
package dcache_pkg;
  localparam int SETS    = 8;
  localparam int BLOCK_W = 32;
  localparam int ADDR_W  = 8;
  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLK_W   = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_W-1:0]   tag;
    logic [BLOCK_W-1:0] data;
  } line_t;

  function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                          input logic [OFF_W-1:0]   off);
    return blk[{off, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM: IDLE -> [WRITEBACK ->] FETCH -> IDLE.
// Each memory state ignores mem_busywait during its first (issue) cycle.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req,
  input  logic   hit,
  input  logic   line_dirty,
  input  logic   mem_busywait,
  output state_t state,
  output logic   latch_en,
  output logic   refill
);
  logic issued;

  assign latch_en = (state == IDLE) & req & ~hit;
  assign refill   = (state == FETCH) & issued & ~mem_busywait;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      issued <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          issued <= 1'b0;
          if (latch_en) state <= line_dirty ? WRITEBACK : FETCH;
        end
        WRITEBACK: begin
          issued <= 1'b1;
          if (issued && !mem_busywait) begin
            state  <= FETCH;
            issued <= 1'b0;
          end
        end
        FETCH: begin
          issued <= 1'b1;
          if (issued && !mem_busywait) begin
            state  <= IDLE;
            issued <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          issued <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back / write-allocate data cache: line arrays, hit
// detection and byte datapath; miss sequencing lives in dcache_ctrl.
module dcache_direct_mapped
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [ADDR_W-1:0]  address,
  input  logic [7:0]         writedata,
  output logic [7:0]         readdata,
  output logic               busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BLK_W-1:0]   mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);
  line_t lines [SETS];

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  line_t            cur;
  logic             req, hit, rd_hit, wr_hit;

  // Block part of the missing address, held for the whole miss sequence.
  logic [BLK_W-1:0] req_blk;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  line_t            r_line;

  state_t state;
  logic   latch_en, refill;

  assign tag = address[ADDR_W-1 -: TAG_W];
  assign idx = address[OFF_W +: IDX_W];
  assign off = address[OFF_W-1:0];
  assign cur = lines[idx];

  assign req    = read | write;
  assign hit    = cur.valid & (cur.tag == tag);
  assign rd_hit = read & ~write & hit;
  assign wr_hit = write & hit & (state == IDLE);

  assign busywait = req & (~hit | (state != IDLE));
  assign readdata = rd_hit ? get_byte(cur.data, off) : 8'h00;

  assign r_tag  = req_blk[BLK_W-1 -: TAG_W];
  assign r_idx  = req_blk[IDX_W-1:0];
  assign r_line = lines[r_idx];

  assign mem_read      = (state == FETCH);
  assign mem_write     = (state == WRITEBACK);
  assign mem_writedata = mem_write ? r_line.data : '0;

  always_comb begin
    mem_address = '0;
    if (mem_write)     mem_address = {r_line.tag, r_idx};
    else if (mem_read) mem_address = {r_tag, r_idx};
  end

  dcache_ctrl u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .hit          (hit),
    .line_dirty   (cur.valid & cur.dirty),
    .mem_busywait (mem_busywait),
    .state        (state),
    .latch_en     (latch_en),
    .refill       (refill)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SETS; i++) begin
        lines[i].valid <= 1'b0;
        lines[i].dirty <= 1'b0;
      end
      req_blk <= '0;
    end else begin
      if (latch_en) req_blk <= address[ADDR_W-1:OFF_W];
      // Refill and write-hit are exclusive: refill only happens outside IDLE.
      if (refill) begin
        lines[r_idx] <= '{valid: 1'b1, dirty: 1'b0, tag: r_tag, data: mem_readdata};
      end else if (wr_hit) begin
        lines[idx].data[{off, 3'b000} +: 8] <= writedata;
        lines[idx].dirty                    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped with a small block memory model.
module tb_dcache_direct_mapped;
  localparam int LAT = 2;
  localparam int CLEAN_STALL = LAT + 3;
  localparam int DIRTY_STALL = 2 * LAT + 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0, write = 1'b0;
  logic [7:0]  address = 8'h00, writedata = 8'h00;
  logic [7:0]  readdata;
  logic        busywait, mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_busywait = 1'b0;

  int n_cmp = 0, n_err = 0;

  logic [31:0] mem [64];
  logic        active = 1'b0, cool = 1'b0, is_wr = 1'b0, overlap = 1'b0;
  int          lat_cnt = 0;
  int          n_rd = 0, n_wr = 0;
  logic [5:0]  rd_addr = '0, wr_addr = '0, cur_addr = '0;
  logic [31:0] wr_data = '0, cur_data = '0;

  always #5 clk = ~clk;

  dcache_direct_mapped dut (
    .clk           (clk),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  assign mem_readdata = mem[mem_address];

  // Memory: busy LAT cycles after seeing a request, then one idle cycle so the
  // still-asserted request at the completion edge is not taken as a new one.
  always @(posedge clk) begin
    if (cool) begin
      cool <= 1'b0;
    end else if (active) begin
      if (lat_cnt > 1) begin
        lat_cnt <= lat_cnt - 1;
      end else begin
        if (is_wr) mem[cur_addr] = cur_data;
        mem_busywait <= 1'b0;
        active       <= 1'b0;
        cool         <= 1'b1;
      end
    end else if (mem_read || mem_write) begin
      active       <= 1'b1;
      lat_cnt      <= LAT;
      mem_busywait <= 1'b1;
      is_wr        <= mem_write;
      cur_addr     <= mem_address;
      cur_data     <= mem_writedata;
      if (mem_write) begin
        n_wr    <= n_wr + 1;
        wr_addr <= mem_address;
        wr_data <= mem_writedata;
      end else begin
        n_rd    <= n_rd + 1;
        rd_addr <= mem_address;
      end
    end
  end

  always @(negedge clk) if (mem_read && mem_write) overlap <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns the byte seen when busywait drops and the
  // number of stalled cycles, and lets the completing edge pass before release.
  task automatic access(input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] q, output int cyc);
    read = r; write = w; address = a; writedata = d;
    cyc = 0;
    #1;
    while (busywait && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) check("access_timeout", 32'(cyc), 32'd0);
    q = readdata;
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] q;
    int cyc, rd_before;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h09] = 32'hDDCCBBAA;
    mem[6'h11] = 32'h11223344;
    mem[6'h38] = 32'h55667788;
    mem[6'h00] = 32'hA1B2C3D4;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_readdata", 32'(readdata), 32'h0);
    check("rst_busywait", 32'(busywait), 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_addr", 32'(mem_address), 32'h0);
    check("rst_mem_wdata", mem_writedata, 32'h0);
    @(negedge clk);

    // Cold read miss on line 1
    access(1'b1, 1'b0, 8'h25, 8'h00, q, cyc);
    check("miss25_data", 32'(q), 32'hBB);
    check("miss25_stall", 32'(cyc), 32'(CLEAN_STALL));
    check("miss25_rd_cnt", 32'(n_rd), 32'd1);
    check("miss25_rd_addr", 32'(rd_addr), 32'h09);
    check("miss25_wr_cnt", 32'(n_wr), 32'd0);

    access(1'b1, 1'b0, 8'h24, 8'h00, q, cyc);
    check("hit24_data", 32'(q), 32'hAA);
    check("hit24_stall", 32'(cyc), 32'd0);

    access(1'b0, 1'b1, 8'h26, 8'h5A, q, cyc);
    check("whit26_stall", 32'(cyc), 32'd0);
    access(1'b1, 1'b0, 8'h26, 8'h00, q, cyc);
    check("rd26_data", 32'(q), 32'h5A);
    check("rd26_stall", 32'(cyc), 32'd0);

    // read and write together behave as a write
    access(1'b1, 1'b1, 8'h24, 8'h99, q, cyc);
    check("rw24_readdata", 32'(q), 32'h00);
    check("rw24_stall", 32'(cyc), 32'd0);
    access(1'b1, 1'b0, 8'h24, 8'h00, q, cyc);
    check("rd24_after_rw", 32'(q), 32'h99);
    check("hits_rd_cnt", 32'(n_rd), 32'd1);
    check("hits_wr_cnt", 32'(n_wr), 32'd0);

    // Conflict on dirty line 1: writeback then fetch
    access(1'b1, 1'b0, 8'h44, 8'h00, q, cyc);
    check("miss44_stall", 32'(cyc), 32'(DIRTY_STALL));
    check("miss44_wr_cnt", 32'(n_wr), 32'd1);
    check("miss44_wr_addr", 32'(wr_addr), 32'h09);
    check("miss44_wr_data", wr_data, 32'hDD5ABB99);
    check("miss44_mem09", mem[6'h09], 32'hDD5ABB99);
    check("miss44_rd_cnt", 32'(n_rd), 32'd2);
    check("miss44_rd_addr", 32'(rd_addr), 32'h11);
    check("miss44_data", 32'(q), 32'h44);

    // Write-allocate on clean miss: block {tag 7, index 0} = 0x38
    access(1'b0, 1'b1, 8'hE3, 8'h77, q, cyc);
    check("wmissE3_stall", 32'(cyc), 32'(CLEAN_STALL));
    check("wmissE3_rd_cnt", 32'(n_rd), 32'd3);
    check("wmissE3_rd_addr", 32'(rd_addr), 32'h38);
    check("wmissE3_wr_cnt", 32'(n_wr), 32'd1);
    access(1'b1, 1'b0, 8'hE3, 8'h00, q, cyc);
    check("rdE3_data", 32'(q), 32'h77);
    access(1'b1, 1'b0, 8'hE2, 8'h00, q, cyc);
    check("rdE2_data", 32'(q), 32'h66);

    // Evicting line 0 proves it was left dirty by the allocating write
    access(1'b1, 1'b0, 8'h03, 8'h00, q, cyc);
    check("miss03_stall", 32'(cyc), 32'(DIRTY_STALL));
    check("miss03_wr_addr", 32'(wr_addr), 32'h38);
    check("miss03_wr_data", wr_data, 32'h77667788);
    check("miss03_rd_addr", 32'(rd_addr), 32'h00);
    check("miss03_data", 32'(q), 32'hA1);
    check("line1_untouched", 32'(n_wr), 32'd2);
    access(1'b1, 1'b0, 8'h44, 8'h00, q, cyc);
    check("rd44_still_hit", 32'(cyc), 32'd0);

    // Reset in the middle of a fetch
    read = 1'b1; address = 8'h25;
    @(negedge clk);
    check("fetch_mem_read", 32'(mem_read), 32'h1);
    check("fetch_mem_addr", 32'(mem_address), 32'h09);
    reset = 1'b0; read = 1'b0;
    @(negedge clk);
    check("midrst_mem_read", 32'(mem_read), 32'h0);
    check("midrst_mem_write", 32'(mem_write), 32'h0);
    check("midrst_busywait", 32'(busywait), 32'h0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    rd_before = n_rd;
    access(1'b1, 1'b0, 8'h25, 8'h00, q, cyc);
    check("rerd25_stall", 32'(cyc), 32'(CLEAN_STALL));
    check("rerd25_rd_cnt", 32'(n_rd), 32'(rd_before + 1));
    check("rerd25_data", 32'(q), 32'hBB);

    check("no_rd_wr_overlap", 32'(overlap), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
